// File: rtl/spi_pkg.sv
// Shared SPI definitions: command encodings and the master state set.
// Used by the master and by the RAM-side slave.
package spi_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        WAIT,
        RECV,
        END
    } spi_state_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_master_shreg.sv
// Frame shift register: parallel load of {cmd,payload}, MSB-first serial out
// towards MOSI, serial in from MISO at the LSB end.
module spi_master_shreg #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned RX_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [RX_W-1:0]  rx_o
);

    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = {data_q[WIDTH-2:0], ser_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_o = data_q[WIDTH-1];

    // Received word as it will stand once the bit currently on ser_i is taken.
    assign rx_o = {data_q[RX_W-2:0], ser_i};

endmodule

// File: rtl/spi_master.sv
// SPI master for the RAM slave: one bit per clk, frames of {cmd, payload}.
// Optional read-data sequencing check enabled by defining SPI_MASTER_CMD_CHECK_EN.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned TURNAROUND = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd,
    input  logic [ADDR_SIZE-1:0] cmd_data,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_data,
    output logic                 err,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int unsigned FRAME_W = ADDR_SIZE + 2;
    localparam int unsigned CNT_MAX = max2(FRAME_W, TURNAROUND);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    spi_state_e           state_q, state_d;
    cnt_t                 cnt_q, cnt_d;
    spi_cmd_e             cmd_q, cmd_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ADDR_SIZE-1:0] rsp_data_q, rsp_data_d;

    logic                 accept;
    logic                 reject;
    logic                 load;
    logic                 shift;
    logic                 ser_out;
    logic [ADDR_SIZE-1:0] rx_word;

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign load      = accept && !reject;
    assign shift     = (state_q == SHIFT) || (state_q == RECV);

`ifdef SPI_MASTER_CMD_CHECK_EN
    logic rd_addr_seen_q, rd_addr_seen_d;
    logic err_q;

    // A read-data frame is only meaningful right after a completed read-address frame.
    assign reject = accept && (cmd == CMD_RD_DATA) && !rd_addr_seen_q;

    always_comb begin
        rd_addr_seen_d = rd_addr_seen_q;
        if (state_q == END) begin
            rd_addr_seen_d = (cmd_q == CMD_RD_ADDR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_seen_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            rd_addr_seen_q <= rd_addr_seen_d;
            err_q          <= reject;
        end
    end

    assign err = err_q;
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    spi_master_shreg #(
        .WIDTH (FRAME_W),
        .RX_W  (ADDR_SIZE)
    ) u_shreg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .load_data_i ({cmd, cmd_data}),
        .shift_i     (shift),
        .ser_i       (MISO),
        .ser_o       (ser_out),
        .rx_o        (rx_word)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    cmd_d   = spi_cmd_e'(cmd);
                    cnt_d   = '0;
                end
            end
            START: begin
                state_d = SHIFT;
                cnt_d   = cnt_t'(FRAME_W - 1);
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    if (cmd_q == CMD_RD_DATA) begin
                        if (TURNAROUND != 0) begin
                            state_d = WAIT;
                            cnt_d   = cnt_t'(TURNAROUND - 1);
                        end else begin
                            state_d = RECV;
                            cnt_d   = cnt_t'(ADDR_SIZE - 1);
                        end
                    end else begin
                        state_d = END;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RECV;
                    cnt_d   = cnt_t'(ADDR_SIZE - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            RECV: begin
                // The last MISO bit is folded in directly so rsp_data is valid during END.
                if (cnt_q == '0) begin
                    state_d     = END;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_word;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            END: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= CMD_WR_ADDR;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign SS_n      = !((state_q == START) || (state_q == SHIFT) ||
                         (state_q == WAIT)  || (state_q == RECV));
    assign MOSI      = ((state_q == START) || (state_q == SHIFT)) && ser_out;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
